// File: rtl/fir_mac_wb_if.sv
// Wishbone slave bundle for fir_mac_wb: classic single-cycle-response bus plus
// the filter's interrupt line.
interface fir_mac_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          int_o;

  modport slave (
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, int_o
  );

  modport master (
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, int_o
  );
endinterface

// File: rtl/fir_mac_wb.sv
// Block FIR filter behind a Wishbone slave: one time-multiplexed MAC, history carried
// across blocks, output shift + saturation. Define FIR_MAC_IRQ_EN for the done interrupt.
module fir_mac_wb #(
  parameter int DW    = 32,
  parameter int SW    = 16,
  parameter int NTAPS = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input logic         wb_clk_i,
  input logic         wb_rst_i,
  fir_mac_wb_if.slave wb
);
  localparam int CAW  = $clog2(NTAPS);
  localparam int XW   = $clog2(DEPTH);
  localparam int ACCW = 2*SW + $clog2(NTAPS);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_HIST} state_e;
  state_e state_q, state_d;

  logic signed [SW-1:0] coef_q [NTAPS];
  logic signed [SW-1:0] x_q    [DEPTH];
  logic signed [SW-1:0] y_q    [DEPTH];
  logic signed [SW-1:0] h_q    [NTAPS-1];

  logic                   ack_q, err_q, done_q, sat_q, busy;
  logic [DW-1:0]          dat_q, rd_data;
  logic [4:0]             shift_q;
  logic [CAW-1:0]         caddr_q, k_q, hidx;
  logic [XW-1:0]          xaddr_q, yaddr_q, n_q;
  logic signed [ACCW-1:0] acc_q, acc_next, shifted;
  logic signed [SW-1:0]   samp, ysat;
  logic signed [2*SW-1:0] prod;
  logic                   clamp, caddr_ok;
  logic [3:0]             idx;
  logic                   access, wr, wr_err, wr_ok, start_go, clr_hist;
`ifdef FIR_MAC_IRQ_EN
  logic                   ien_q, int_q;
`endif
  logic                   unused;

  function automatic logic [DW-1:0] sext(input logic signed [SW-1:0] v);
    return DW'(v);
  endfunction

  assign busy     = (state_q != S_IDLE);
  assign idx      = wb.wb_adr_i[5:2];
  assign access   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign wr       = access & wb.wb_we_i;
  // Config/data writes and history clear would corrupt a run in flight; they get err instead.
  assign wr_err   = wr & busy & (((idx >= 4'd2) && (idx <= 4'd6)) ||
                                 ((idx == 4'd0) && wb.wb_dat_i[1]));
  assign wr_ok    = wr & ~wr_err;
  assign start_go = wr_ok & (idx == 4'd0) & wb.wb_dat_i[0] & ~busy;
  assign clr_hist = wr_ok & (idx == 4'd0) & wb.wb_dat_i[1];
  assign caddr_ok = int'(caddr_q) < NTAPS;
  assign unused   = ^{wb.wb_sel_i, wb.wb_adr_i[AW-1:6], wb.wb_adr_i[1:0], wb.wb_dat_i};

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;
`ifdef FIR_MAC_IRQ_EN
  assign wb.int_o = int_q;
`else
  assign wb.int_o = 1'b0;
`endif

  // Tap k of output n reads X[n-k]; negative indices fall back into the previous block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    samp = '0;
    hidx = k_q - CAW'(n_q) - CAW'(1);
    if (int'(n_q) >= int'(k_q)) samp = x_q[n_q - XW'(k_q)];
    else                        samp = h_q[hidx];
  end

  assign prod     = (2*SW)'(coef_q[k_q]) * (2*SW)'(samp);
  assign acc_next = ((k_q == '0) ? '0 : acc_q) + ACCW'(prod);

  always_comb begin
    shifted = acc_q >>> shift_q;
    clamp   = 1'b1;
    if (shifted > SMAX)      ysat = SMAX[SW-1:0];
    else if (shifted < SMIN) ysat = SMIN[SW-1:0];
    else begin
      ysat  = shifted[SW-1:0];
      clamp = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_MAC;
      S_MAC:   if (k_q == CAW'(NTAPS-1)) state_d = S_STORE;
      S_STORE: state_d = (n_q == XW'(DEPTH-1)) ? S_HIST : S_MAC;
      S_HIST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      4'd1: rd_data[2:0]     = {sat_q, done_q, busy};
      4'd2: rd_data[4:0]     = shift_q;
      4'd3: rd_data[CAW-1:0] = caddr_q;
      4'd4: if (caddr_ok) rd_data = sext(coef_q[caddr_q]);
      4'd5: rd_data[XW-1:0]  = xaddr_q;
      4'd6: rd_data          = sext(x_q[xaddr_q]);
      4'd7: rd_data[XW-1:0]  = yaddr_q;
      4'd8: rd_data          = sext(y_q[yaddr_q]);
`ifdef FIR_MAC_IRQ_EN
      4'd9: rd_data[0]       = ien_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!wb_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      shift_q <= '0;
      caddr_q <= '0;
      xaddr_q <= '0;
      yaddr_q <= '0;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
`ifdef FIR_MAC_IRQ_EN
      ien_q   <= 1'b0;
      int_q   <= 1'b0;
`endif
      // NOTE: the arrays must read 0 after reset, so they are flop banks, not inferred RAM.
      for (int i = 0; i < NTAPS; i++)   coef_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++)   x_q[i]    <= '0;
      for (int i = 0; i < DEPTH; i++)   y_q[i]    <= '0;
      for (int i = 0; i < NTAPS-1; i++) h_q[i]    <= '0;
    end else begin
      ack_q <= access & ~wr_err;
      err_q <= wr_err;
      dat_q <= (access & ~wb.wb_we_i) ? rd_data : '0;
`ifdef FIR_MAC_IRQ_EN
      int_q <= ien_q & done_q;
`endif
      if (wr_ok) begin
        case (idx)
          4'd1: begin
            if (wb.wb_dat_i[1]) done_q <= 1'b0;
            if (wb.wb_dat_i[2]) sat_q  <= 1'b0;
          end
          4'd2: shift_q <= wb.wb_dat_i[4:0];
          4'd3: caddr_q <= wb.wb_dat_i[CAW-1:0];
          4'd4: if (caddr_ok) begin
            coef_q[caddr_q] <= wb.wb_dat_i[SW-1:0];
            caddr_q <= (caddr_q == CAW'(NTAPS-1)) ? '0 : caddr_q + CAW'(1);
          end
          4'd5: xaddr_q <= wb.wb_dat_i[XW-1:0];
          4'd6: begin
            x_q[xaddr_q] <= wb.wb_dat_i[SW-1:0];
            xaddr_q      <= xaddr_q + XW'(1);
          end
          4'd7: yaddr_q <= wb.wb_dat_i[XW-1:0];
`ifdef FIR_MAC_IRQ_EN
          4'd9: ien_q   <= wb.wb_dat_i[0];
`endif
          default: ;
        endcase
      end
      if (clr_hist) for (int i = 0; i < NTAPS-1; i++) h_q[i] <= '0;
      if (start_go) begin
        done_q <= 1'b0;
        k_q    <= '0;
        n_q    <= '0;
      end
      // Datapath updates come last so a same-cycle sat/done set wins over a W1C.
      case (state_q)
        S_MAC: begin
          acc_q <= acc_next;
          k_q   <= (k_q == CAW'(NTAPS-1)) ? '0 : k_q + CAW'(1);
        end
        S_STORE: begin
          y_q[n_q] <= ysat;
          if (clamp) sat_q <= 1'b1;
          n_q <= n_q + XW'(1);
        end
        S_HIST: begin
          for (int j = 0; j < NTAPS-1; j++) h_q[j] <= x_q[DEPTH-1-j];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_wb.sv
// Directed self-checking bench for fir_mac_wb (NTAPS=16, DEPTH=32) with hand-computed vectors.
module tb_fir_mac_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_wb_if #(.AW(32), .DW(32)) bus ();

  fir_mac_wb #(.DW(32), .SW(16), .NTAPS(16), .DEPTH(32), .AW(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb       (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic xfer(input bit we, input int idx, input logic [31:0] wdat,
                      output logic [31:0] rdat, output bit err);
    int waitc;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = 32'(idx) << 2;
    bus.wb_dat_i = wdat;
    bus.wb_sel_i = 4'hF;
    waitc = 0;
    do begin
      @(posedge clk); #1;
      waitc++;
    end while (!(bus.wb_ack_o || bus.wb_err_o) && waitc < 8);
    rdat = bus.wb_dat_o;
    err  = bus.wb_err_o;
    if (!(bus.wb_ack_o || bus.wb_err_o)) begin
      n_tests++; n_fail++;
      $display("FAIL bus_timeout idx=%0d: got no ack/err, required a response", idx);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] r; bit e;
    xfer(1'b1, idx, d, r, e);
  endtask

  task automatic wr_e(input int idx, input logic [31:0] d, output bit e);
    logic [31:0] r;
    xfer(1'b1, idx, d, r, e);
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    bit e;
    xfer(1'b0, idx, 32'h0, d, e);
  endtask

  task automatic get_y(input int n, output logic [31:0] v);
    wr(7, 32'(n));
    rd(8, v);
  endtask

  task automatic fill_coef(input logic [31:0] v);
    wr(3, 0);
    for (int i = 0; i < 16; i++) wr(4, v);
  endtask

  task automatic fill_x(input logic [31:0] v);
    wr(5, 0);
    for (int i = 0; i < 32; i++) wr(6, v);
  endtask

  task automatic wait_idle(input int t0, output int dur);
    int guard = 0;
    while (dut.busy && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    dur = cyc_cnt - t0;
    if (dut.busy) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: busy still 1 after %0d cycles", guard);
    end
  endtask

  task automatic run_block(input logic [31:0] ctrl, output int dur);
    int t0;
    wr(0, ctrl);
    t0 = cyc_cnt;
    wait_idle(t0, dur);
  endtask

  task automatic test_reset();
    logic [31:0] d; bit e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.wb_ack_o, bus.wb_err_o, bus.int_o} !== 3'b000 || bus.wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack/err/int=%b%b%b dat=%h, required 000 / 0",
               bus.wb_ack_o, bus.wb_err_o, bus.int_o, bus.wb_dat_o);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, i, 32'h0, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read idx=%0d: got data=%h err=%b, required 0 / 0", i, d, e);
      end
    end
  endtask

  task automatic test_impulse();
    logic [31:0] d; int dur;
    wr(3, 0);
    for (int k = 0; k < 16; k++) wr(4, 32'(k + 1));
    fill_x(0);
    wr(5, 0);
    wr(6, 1);
    rd(3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL caddr_wrap: got %h, required 0", d); end
    rd(5, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL xaddr_inc: got %h, required 1", d); end
    wr(3, 5);
    rd(4, d);
    n_tests++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL cdata_read: got %h, required 6", d); end
    run_block(32'h1, dur);
    n_tests++;
    if (dur !== 545) begin n_fail++; $display("FAIL impulse_busy_cycles: got %0d, required 545", dur); end
    rd(1, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL impulse_status: got %h, required 2", d); end
    for (int n = 0; n < 32; n++) begin
      get_y(n, d);
      n_tests++;
      if (d !== ((n < 16) ? 32'(n + 1) : 32'h0)) begin
        n_fail++;
        $display("FAIL impulse_y[%0d]: got %h, required %h", n, d, (n < 16) ? 32'(n + 1) : 32'h0);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] d, exp_v; int dur;
    wr(0, 32'h2);
    fill_coef(1);
    fill_x(1);
    for (int r = 0; r < 3; r++) begin
      run_block((r == 2) ? 32'h3 : 32'h1, dur);
      for (int n = 0; n < 32; n++) begin
        exp_v = (r == 1 || n >= 15) ? 32'd16 : 32'(n + 1);
        get_y(n, d);
        n_tests++;
        if (d !== exp_v) begin
          n_fail++;
          $display("FAIL stream_run%0d_y[%0d]: got %h, required %h", r, n, d, exp_v);
        end
      end
    end
  endtask

  task automatic test_sat_shift();
    logic [31:0] d; int dur;
    fill_coef(32'h7FFF);
    fill_x(32'h7FFF);
    wr(2, 0);
    run_block(32'h1, dur);
    get_y(31, d);
    n_tests++;
    if (d !== 32'h0000_7FFF) begin n_fail++; $display("FAIL sat_pos_y31: got %h, required 00007fff", d); end
    rd(1, d);
    n_tests++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL sat_status: got %h, required 6", d); end
    wr(1, 32'h4);
    rd(1, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL sat_w1c: got %h, required 2", d); end

    fill_coef(0);
    wr(3, 0); wr(4, 32'h4000);
    fill_x(0);
    wr(5, 0); wr(6, 32'h4000); wr(6, 32'h8000);
    wr(2, 15);
    rd(2, d);
    n_tests++;
    if (d !== 32'd15) begin n_fail++; $display("FAIL shift_read: got %h, required f", d); end
    run_block(32'h1, dur);
    get_y(0, d);
    n_tests++;
    if (d !== 32'h0000_2000) begin n_fail++; $display("FAIL shift_y0: got %h, required 00002000", d); end
    get_y(1, d);
    n_tests++;
    if (d !== 32'hFFFF_C000) begin n_fail++; $display("FAIL shift_neg_y1: got %h, required ffffc000", d); end
    rd(1, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL shift_no_sat: got %h, required 2", d); end

    wr(2, 0);
    wr(3, 0); wr(4, 32'h7FFF);
    wr(5, 0); wr(6, 32'h8000);
    run_block(32'h1, dur);
    get_y(0, d);
    n_tests++;
    if (d !== 32'hFFFF_8000) begin n_fail++; $display("FAIL sat_neg_y0: got %h, required ffff8000", d); end
    rd(1, d);
    n_tests++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL sat_neg_status: got %h, required 6", d); end
    wr(1, 32'h6);
  endtask

  task automatic test_busy_protect();
    logic [31:0] d; bit e; int t0, dur;
    wr(5, 3);
    wr(0, 32'h1);
    t0 = cyc_cnt;
    rd(1, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL busy_status_read: got %h, required 1", d); end
    wr_e(6, 32'h1234, e);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_xdata_err: got err=%b, required 1", e); end
    @(posedge clk); #1;
    n_tests++;
    if (bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got err=%b, required 0", bus.wb_err_o); end
    wr_e(2, 7, e);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_shift_err: got err=%b, required 1", e); end
    wr_e(0, 32'h1, e);
    n_tests++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL busy_start_ack: got err=%b, required 0", e); end
    wr_e(0, 32'h2, e);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_clrhist_err: got err=%b, required 1", e); end
    wr_e(3, 9, e);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_caddr_err: got err=%b, required 1", e); end
    wr_e(7, 5, e);
    n_tests++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL busy_yaddr_ok: got err=%b, required 0", e); end
    wait_idle(t0, dur);
    n_tests++;
    if (dur !== 545) begin n_fail++; $display("FAIL busy_protect_cycles: got %0d, required 545", dur); end
    rd(2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL protect_shift: got %h, required 0", d); end
    rd(5, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL protect_xaddr: got %h, required 3", d); end
    rd(6, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL protect_xdata: got %h, required 0", d); end
    rd(3, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL protect_caddr: got %h, required 1", d); end
    rd(7, d);
    n_tests++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL protect_yaddr: got %h, required 5", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; int t0, dur;
`ifdef FIR_MAC_IRQ_EN
    wr(9, 1);
    rd(9, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ien_read: got %h, required 1", d); end
    wr(0, 32'h1);
    t0 = cyc_cnt;
    wait_idle(t0, dur);
    n_tests++;
    if (bus.int_o !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle: got int=%b, required 0", bus.int_o); end
    @(posedge clk); #1;
    n_tests++;
    if (bus.int_o !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got int=%b, required 1", bus.int_o); end
    wr(1, 32'h2);
    n_tests++;
    if (bus.int_o !== 1'b1) begin n_fail++; $display("FAIL irq_hold_at_ack: got int=%b, required 1", bus.int_o); end
    @(posedge clk); #1;
    n_tests++;
    if (bus.int_o !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got int=%b, required 0", bus.int_o); end
`else
    int highs = 0;
    int guard = 0;
    wr(9, 1);
    rd(9, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ien_absent_read: got %h, required 0", d); end
    wr(0, 32'h1);
    t0 = cyc_cnt;
    while ((dut.busy || guard < 560) && guard < 2000) begin
      @(posedge clk); #1;
      if (bus.int_o !== 1'b0) highs++;
      guard++;
    end
    dur = cyc_cnt - t0;
    n_tests++;
    if (highs !== 0) begin n_fail++; $display("FAIL irq_tied_low: got %0d int cycles in %0d, required 0", highs, dur); end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    wr(2, 3);
    wr(0, 32'h1);
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", dut.busy); end
    @(negedge clk) rst_n = 1'b1;
    rd(1, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h, required 0", d); end
    rd(2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_shift: got %h, required 0", d); end
    rd(4, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_coef0: got %h, required 0", d); end
    get_y(0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_y0: got %h, required 0", d); end
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = 4'hF;
    test_reset();
    test_impulse();
    test_stream();
    test_sat_shift();
    test_busy_protect();
    test_irq();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_mac_wb.md
Name: fir_mac_wb

Overview:
- Wishbone-slave block FIR filter, parametrised successor of the fixed 32-sample DSP FIR core.
- Software loads coefficients and a block of input samples, starts the engine, then reads filtered outputs.
- A single time-multiplexed MAC runs under an FSM.
- Filter history carries across blocks for continuous streaming, with output shift, saturation and sticky status.

Parameters:
- DW, 32: Wishbone data width.
- SW, 16: signed sample and coefficient width.
- NTAPS, 16: number of taps (2..64).
- DEPTH, 32: samples per block (power of 2; DEPTH >= NTAPS-1).
- AW, 32: Wishbone address width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  AW  byte address; word index is wb_adr_i[5:2].
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects; ignored, full-word access only.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data; registered, valid with ack.
- wb_ack_o  out  1  access acknowledge.
- wb_err_o  out  1  access error.
- int_o  out  1  interrupt.

Behaviour:
- Reset (wb_rst_i=0, async):
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, int_o=0.
  - FSM=IDLE; busy=0, done=0, sat=0, SHIFT=0; all address pointers 0.
  - Coefficient, X, Y and history arrays all 0.
- Bus handshake:
  - An access is wb_cyc_i & wb_stb_i while wb_ack_o=0 and wb_err_o=0.
  - Exactly one of ack/err is asserted for one cycle, the cycle after the access.
  - A master holding stb gets one response per two cycles.
- Register map (word index):
  - 0 CTRL, W: bit0 START, bit1 CLRHIST. Both self-clearing. Reads 0.
  - 1 STATUS, R: {sat,done,busy} in bits [2:0]. W: bit1 and bit2 are write-1-to-clear.
  - 2 SHIFT, RW: [4:0] arithmetic right shift applied to the accumulator.
  - 3 CADDR, RW: coefficient pointer.
  - 4 CDATA, W: writes coef[CADDR] from [SW-1:0], then CADDR increments. R: returns coef[CADDR], sign-extended.
  - 5 XADDR, RW: input-sample pointer.
  - 6 XDATA, W: writes X[XADDR], then XADDR increments. R: returns X[XADDR], no increment.
  - 7 YADDR, RW: output pointer.
  - 8 YDATA, R: returns Y[YADDR] sign-extended; no side effect.
  - 9 IEN: described under Optional Feature. Other indices read 0; writes to them ack and are ignored.
- Pointers are written with the low log2(range) bits only.
- Auto-increment wraps: CADDR at NTAPS-1 goes to 0; XADDR at DEPTH-1 goes to 0.
- Out-of-range CADDR reads 0 and writes are ignored.
- Error rule: while busy=1, any write to indices 2-6 or CTRL.CLRHIST gets wb_err_o and no state change. Reads are always allowed; YDATA returns stale data while busy.
- START:
  - START with busy=0: clears done, sets busy the next cycle, FSM goes to MAC.
  - START with busy=1: ignored, acks normally.
  - START+CLRHIST in the same write: history is cleared first, then the run starts.
- FSM: IDLE -> MAC -> STORE -> MAC ... -> HIST -> IDLE.
  - MAC: NTAPS cycles, k=0..NTAPS-1. acc += coef[k]*s(n-k), where s(m)=X[m] for m>=0 and s(m)=H[-m-1] for m<0.
  - acc is cleared at k=0.
  - STORE: 1 cycle. Y[n] = sat_SW(acc >>> SHIFT); n increments; goes to HIST after n=DEPTH-1.
  - HIST: 1 cycle. H[j] = X[DEPTH-1-j] for j=0..NTAPS-2.
  - Exit HIST: busy=0, done=1.
- Busy duration is exactly DEPTH*(NTAPS+1)+1 cycles.
- Arithmetic:
  - Products are signed 2*SW bits.
  - acc is 2*SW+ceil(log2 NTAPS) bits and never overflows.
  - Saturation clamps to [-2^(SW-1), 2^(SW-1)-1]. Any clamp sets sticky sat.
- Reset mid-run aborts immediately; all state returns to reset values.

Optional Feature:
- Macro FIR_MAC_IRQ_EN.
- Defined:
  - IEN register [0] enables the done interrupt; reset value 0.
  - int_o = IEN[0] & done, registered. It deasserts the cycle after done is cleared by W1C or START.
- Undefined:
  - int_o tied to 0.
  - Index 9 reads 0 and writes are ignored.

Test Plan:
- Reset, then read every index -> all return 0. No err on any read.
- Impulse, defaults, SHIFT=0:
  - Setup: coef[k]=k+1 for k=0..15 via CDATA auto-increment; X[0]=1, others 0; START.
  - Poll: busy=1 for exactly 545 cycles.
  - Result: Y[0..15]=1..16, Y[16..31]=0, done=1, sat=0.
- Streaming history:
  - Setup: coef all 1; X all 0x0001; run twice.
  - First run: Y[n]=n+1 for n<15, 16 thereafter.
  - Second run: all Y=16. After CLRHIST, a third run repeats the first-run result.
- Saturation/shift:
  - Coef all 0x7FFF, X all 0x7FFF, SHIFT=0 -> Y[31]=0x00007FFF, sat=1.
  - Then W1C sat -> sat reads 0.
  - SHIFT=15 with coef[0]=0x4000, X[0]=0x4000, others 0 -> Y[0]=0x00002000.
- Busy protection: write XDATA and SHIFT during a run -> wb_err_o one cycle each; X and SHIFT unchanged; a second START is ignored; busy count stays 545.
- IRQ (macro defined): IEN=1, START -> int_o rises one cycle after done; writing STATUS=0x2 drops int_o next cycle. Macro undefined -> int_o stays 0.
